// File: rtl/evm_pkg.sv
// Shared types, defaults and helpers for the multi-candidate voting machine.
package evm_pkg;

    localparam int DEF_NUM_CAND = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_TIMEOUT  = 100;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAND,
        WAIT_VOTE,
        VOTED,
        TALLY,
        DONE
    } evm_state_e;

    // Index 0 is reserved for "no candidate", so NUM_CAND+1 codes are needed.
    function automatic int name_width(input int num_cand);
        return $clog2(num_cand + 1);
    endfunction

endpackage

// File: rtl/evm_multi_if.sv
// Ballot-unit / display-controller bundle of the voting machine.
interface evm_multi_if import evm_pkg::*; #(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NAME_W   = name_width(NUM_CAND)
);

    logic                switch_on_evm;
    logic                candidate_ready;
    logic [NUM_CAND-1:0] vote;
    logic                voting_session_done;
    logic [NAME_W-1:0]   display_sel;
    logic                display_winner;

    logic [NAME_W-1:0]   candidate_name;
    logic [WIDTH-1:0]    results;
    logic                invalid_results;
    logic                voting_in_progress;
    logic                voting_done;
    logic                vote_rejected;
    logic                count_saturated;

    modport master (
        output switch_on_evm, candidate_ready, vote, voting_session_done,
               display_sel, display_winner,
        input  candidate_name, results, invalid_results, voting_in_progress,
               voting_done, vote_rejected, count_saturated
    );

    modport slave (
        input  switch_on_evm, candidate_ready, vote, voting_session_done,
               display_sel, display_winner,
        output candidate_name, results, invalid_results, voting_in_progress,
               voting_done, vote_rejected, count_saturated
    );

endinterface

// File: rtl/evm_tally_scan.sv
// Sequential max/argmax/tie scanner: walks one candidate per cycle while start is high.
module evm_tally_scan import evm_pkg::*; #(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      start,
    input  logic [NUM_CAND*WIDTH-1:0] tallies,
    output logic                      done,
    output logic [WIDTH-1:0]          max,
    output logic [IDX_W-1:0]          argmax,
    output logic                      tie
);

    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] cur;

    assign cur  = tallies[int'(idx) * WIDTH +: WIDTH];
    // High during the last scan cycle so the controller leaves TALLY on that edge.
    assign done = start && (idx == IDX_W'(NUM_CAND - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx    <= '0;
            max    <= '0;
            argmax <= '0;
            tie    <= 1'b0;
        end else if (clear) begin
            idx    <= '0;
            max    <= '0;
            argmax <= '0;
            tie    <= 1'b0;
        end else if (start) begin
            idx <= done ? '0 : idx + IDX_W'(1);
            if (idx == '0) begin
                max    <= cur;
                argmax <= '0;
                tie    <= 1'b0;
            end else if (cur > max) begin
                max    <= cur;
                argmax <= idx;
                tie    <= 1'b0;
            end else if (cur == max) begin
                tie    <= 1'b1;
            end
        end else begin
            idx <= '0;
        end
    end

endmodule

// File: rtl/evm_multi.sv
// Parametrised voting machine: ballot capture, saturating tallies, timeouts and result display.
module evm_multi import evm_pkg::*; #(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int NAME_W   = name_width(NUM_CAND)
) (
    input logic        clk,
    input logic        rst,
    evm_multi_if.slave bus
);

    localparam int               IDX_W     = $clog2(NUM_CAND);
    localparam int               TMR_W     = $clog2(TIMEOUT);
    localparam logic [WIDTH-1:0] TALLY_MAX = '1;

    evm_state_e                state, state_next;
    logic [TMR_W-1:0]          timer;
    logic [WIDTH-1:0]          tally [NUM_CAND];
    logic [NUM_CAND*WIDTH-1:0] tally_flat;
    logic [IDX_W-1:0]          sel_idx, vote_idx, disp_idx;
    logic                      vote_rejected, count_saturated;
    logic                      clear_all, ballot_valid, ballot_multi, timeout;
    logic                      scan_done, scan_tie;
    logic [WIDTH-1:0]          scan_max;
    logic [IDX_W-1:0]          scan_argmax;
    logic [NAME_W-1:0]         name_d;
    logic [WIDTH-1:0]          results_d;
    logic                      invalid_d;

    assign clear_all    = !bus.switch_on_evm || (state == IDLE);
    assign ballot_multi = $countones(bus.vote) > 1;
    assign ballot_valid = ($countones(bus.vote) == 1) && !bus.candidate_ready;
    assign timeout      = (timer == TMR_W'(TIMEOUT - 1));

    always_comb begin
        vote_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (bus.vote[i]) vote_idx = IDX_W'(i);
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (!bus.switch_on_evm) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      state_next = WAIT_CAND;
                WAIT_CAND: begin
                    if (bus.candidate_ready)          state_next = WAIT_VOTE;
                    else if (bus.voting_session_done) state_next = TALLY;
                    else if (timeout)                 state_next = TALLY;
                end
                WAIT_VOTE: begin
                    if (ballot_valid) state_next = VOTED;
                    else if (timeout) state_next = WAIT_CAND;
                end
                VOTED:     state_next = bus.candidate_ready ? WAIT_VOTE : WAIT_CAND;
                TALLY:     if (scan_done) state_next = DONE;
                DONE:      state_next = DONE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Dwell timer restarts on every state change, including re-entry from VOTED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if ((state_next == state) &&
                     (state == WAIT_CAND || state == WAIT_VOTE)) begin
            timer <= timer + TMR_W'(1);
        end else begin
            timer <= '0;
        end
    end

    // NOTE: the tally array is a handful of flops, not a RAM, so it is reset
    // explicitly; a memory macro would instead need a clear sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
            sel_idx         <= '0;
            count_saturated <= 1'b0;
        end else if (clear_all) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
            sel_idx         <= '0;
            count_saturated <= 1'b0;
        end else begin
            if (state == WAIT_VOTE && ballot_valid) sel_idx <= vote_idx;
            if (state == VOTED) begin
                if (tally[sel_idx] == TALLY_MAX) count_saturated <= 1'b1;
                else                             tally[sel_idx] <= tally[sel_idx] + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vote_rejected <= 1'b0;
        else      vote_rejected <= bus.switch_on_evm && (state == WAIT_VOTE) && ballot_multi;
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_flat
        assign tally_flat[g*WIDTH +: WIDTH] = tally[g];
    end

    evm_tally_scan #(
        .NUM_CAND (NUM_CAND),
        .WIDTH    (WIDTH),
        .IDX_W    (IDX_W)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_all),
        .start   (state == TALLY),
        .tallies (tally_flat),
        .done    (scan_done),
        .max     (scan_max),
        .argmax  (scan_argmax),
        .tie     (scan_tie)
    );

    // Per-candidate tallies stay viewable even when the top count is shared.
    always_comb begin
        name_d    = '0;
        results_d = '0;
        invalid_d = 1'b0;
        disp_idx  = IDX_W'(bus.display_sel - NAME_W'(1));
        if (state == DONE) begin
            invalid_d = scan_tie;
            if (bus.display_winner) begin
                if (!scan_tie) begin
                    name_d    = NAME_W'(scan_argmax) + NAME_W'(1);
                    results_d = scan_max;
                end
            end else if (bus.display_sel != '0 && bus.display_sel <= NAME_W'(NUM_CAND)) begin
                name_d    = bus.display_sel;
                results_d = tally[disp_idx];
            end
        end
    end

    assign bus.candidate_name     = name_d;
    assign bus.results            = results_d;
    assign bus.invalid_results    = invalid_d;
    assign bus.voting_in_progress = (state == WAIT_VOTE);
    assign bus.voting_done        = (state == DONE);
    assign bus.vote_rejected      = vote_rejected;
    assign bus.count_saturated    = count_saturated;

endmodule
